// File: rtl/picobello_pkg.sv
// Picobello multicast SAM types, the default multicast rule table and the mesh origin.
package picobello_pkg;

  localparam int unsigned SamAddrWidth = 48;
  localparam int unsigned CoordWidth   = 4;
  localparam int unsigned PortIdWidth  = 2;

  typedef struct packed {
    logic [PortIdWidth-1:0] port_id;
    logic [CoordWidth-1:0]  y;
    logic [CoordWidth-1:0]  x;
  } id_t;

  typedef struct packed {
    logic [5:0] offset;
    logic [3:0] len;
  } mask_sel_t;

  typedef struct packed {
    id_t                     idx;
    mask_sel_t               mask_x;
    mask_sel_t               mask_y;
    logic [SamAddrWidth-1:0] start_addr;
    logic [SamAddrWidth-1:0] end_addr;
  } sam_multicast_rule_t;

  localparam int unsigned SamNumRules = 2;
  localparam int unsigned ClusterX0Y0 = 0;

  // Cluster window: X tile index in addr[21:20], Y tile index in addr[19:18].
  localparam sam_multicast_rule_t ClusterRule = '{
    idx:        '{port_id: 2'd1, y: 4'd0, x: 4'd0},
    mask_x:     '{offset: 6'd20, len: 4'd2},
    mask_y:     '{offset: 6'd18, len: 4'd2},
    start_addr: 48'h0000_2000_0000,
    end_addr:   48'h0000_2040_0000
  };

  localparam sam_multicast_rule_t PeriphRule = '{
    idx:        '{port_id: 2'd3, y: 4'd2, x: 4'd5},
    mask_x:     '{offset: 6'd0, len: 4'd0},
    mask_y:     '{offset: 6'd0, len: 4'd0},
    start_addr: 48'h0000_3000_0000,
    end_addr:   48'h0000_3000_1000
  };

  localparam sam_multicast_rule_t [SamNumRules-1:0] SamMcast = {PeriphRule, ClusterRule};

  localparam logic [CoordWidth-1:0] McastX0 = SamMcast[ClusterX0Y0].idx.x;
  localparam logic [CoordWidth-1:0] McastY0 = SamMcast[ClusterX0Y0].idx.y;

endpackage

// File: rtl/picobello_mcast_pdep.sv
// Parallel bit deposit: the low-order bits of cnt_i land, in order, on the set bits of mask_i.
module picobello_mcast_pdep #(
  parameter int unsigned MaxMaskBits = 12
) (
  input  logic [MaxMaskBits-1:0] cnt_i,
  input  logic [MaxMaskBits-1:0] mask_i,
  output logic [MaxMaskBits-1:0] data_o
);

  localparam int unsigned IdxW = (MaxMaskBits > 1) ? $clog2(MaxMaskBits) : 1;

  // rank[gi] = number of mask bits set below position gi = which cnt bit lands there.
  logic [IdxW-1:0] rank [MaxMaskBits];

  for (genvar gi = 0; gi < MaxMaskBits; gi++) begin : g_bit
    if (gi == 0) begin : g_first
      assign rank[gi] = '0;
    end else begin : g_rest
      assign rank[gi] = rank[gi-1] + IdxW'(mask_i[gi-1]);
    end
    assign data_o[gi] = mask_i[gi] & cnt_i[rank[gi]];
  end

endmodule

// File: rtl/picobello_mcast_expander.sv
// Expands one multicast request into a serial stream of unicast destination IDs.
// Optional PICOBELLO_MCAST_EXPANDER_ERR_EN: unmatched addresses / masked unicast rules emit an error beat.
module picobello_mcast_expander
  import picobello_pkg::*;
#(
  parameter int unsigned                             NumRules    = SamNumRules,
  parameter sam_multicast_rule_t [NumRules-1:0]      Sam         = SamMcast,
  parameter int unsigned                             AddrWidth   = SamAddrWidth,
  parameter int unsigned                             MaxMaskBits = 12,
  parameter logic [CoordWidth-1:0]                   X0          = McastX0,
  parameter logic [CoordWidth-1:0]                   Y0          = McastY0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_mask_i,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output id_t                  dst_id_o,
  output logic                 dst_last_o,
  output logic                 dst_err_o
);

  localparam int unsigned CntW = MaxMaskBits + 1;
  localparam int unsigned CmpW = (AddrWidth > SamAddrWidth) ? AddrWidth : SamAddrWidth;
  localparam int unsigned SelW = $bits(id_t) + 2 * $bits(mask_sel_t);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
    ERR,
`endif
    EXPAND
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q, mask_q;
  logic [CntW-1:0]        cnt_q, total_q;
  logic [MaxMaskBits-1:0] m_q, b_q;
  logic [3:0]             ly_q;
  logic                   mcast_q;
  id_t                    base_q;
  logic                   dst_valid_q, dst_last_q;
  id_t                    dst_id_q;

  function automatic logic [MaxMaskBits-1:0] len_mask(input logic [3:0] len);
    return (MaxMaskBits'(1) << len) - MaxMaskBits'(1);
  endfunction

  function automatic logic [MaxMaskBits-1:0] field(input logic [AddrWidth-1:0] v, input mask_sel_t sel);
    return MaxMaskBits'(v >> sel.offset) & len_mask(sel.len);
  endfunction

  // Rule match with lowest-index priority, reduced to the fields the expansion needs.
  logic [NumRules-1:0] match, first_hit;
  logic [SelW-1:0]     sel_chain [NumRules+1];
  id_t                 lk_idx;
  mask_sel_t           lk_sel_x, lk_sel_y;

  assign sel_chain[0] = '0;
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
    assign match[gi] = (CmpW'(addr_q) >= CmpW'(Sam[gi].start_addr)) &&
                       (CmpW'(addr_q) <  CmpW'(Sam[gi].end_addr));
    assign sel_chain[gi+1] = sel_chain[gi] |
        (first_hit[gi] ? {Sam[gi].idx, Sam[gi].mask_x, Sam[gi].mask_y} : SelW'(0));
  end
  assign first_hit = match & (~match + NumRules'(1));
  assign {lk_idx, lk_sel_x, lk_sel_y} = sel_chain[NumRules];

  logic                   lk_mcast;
  logic [MaxMaskBits-1:0] lk_m, lk_b;
  logic [CntW-1:0]        lk_total;

  // y occupies the low bits so it is the fastest-varying coordinate.
  assign lk_mcast = (lk_sel_x.len != '0) || (lk_sel_y.len != '0);
  assign lk_m     = (field(mask_q, lk_sel_x) << lk_sel_y.len) | field(mask_q, lk_sel_y);
  assign lk_b     = (field(addr_q, lk_sel_x) << lk_sel_y.len) | field(addr_q, lk_sel_y);
  assign lk_total = (CntW'(1) << $countones(lk_m)) - CntW'(1);

`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
  logic lk_err, err_q;
  assign lk_err = !(|match) || (!lk_mcast && (mask_q != '0));
`endif

  // Next beat to present: beat 0 from the lookup, otherwise beat cnt+1 from latched state.
  logic [CntW-1:0]        nxt_cnt, nxt_total;
  logic [MaxMaskBits-1:0] nxt_m, nxt_b, dep, coord;
  logic [3:0]             nxt_ly;
  logic                   nxt_mcast, nxt_last;
  id_t                    nxt_base, nxt_id;

  always_comb begin
    if (state_q == LOOKUP) begin
      nxt_cnt   = '0;
      nxt_total = lk_total;
      nxt_m     = lk_m;
      nxt_b     = lk_b;
      nxt_ly    = lk_sel_y.len;
      nxt_mcast = lk_mcast;
      nxt_base  = lk_idx;
    end else begin
      nxt_cnt   = cnt_q + CntW'(1);
      nxt_total = total_q;
      nxt_m     = m_q;
      nxt_b     = b_q;
      nxt_ly    = ly_q;
      nxt_mcast = mcast_q;
      nxt_base  = base_q;
    end
  end

  picobello_mcast_pdep #(
    .MaxMaskBits (MaxMaskBits)
  ) i_pdep (
    .cnt_i  (nxt_cnt[MaxMaskBits-1:0]),
    .mask_i (nxt_m),
    .data_o (dep)
  );

  assign coord    = (nxt_b & ~nxt_m) | dep;
  assign nxt_last = (nxt_cnt == nxt_total);

  always_comb begin
    nxt_id = nxt_base;
    if (nxt_mcast) begin
      nxt_id.x = X0 + CoordWidth'(coord >> nxt_ly);
      nxt_id.y = Y0 + CoordWidth'(coord & len_mask(nxt_ly));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      m_q         <= '0;
      b_q         <= '0;
      ly_q        <= '0;
      mcast_q     <= 1'b0;
      base_q      <= '0;
      dst_valid_q <= 1'b0;
      dst_id_q    <= '0;
      dst_last_q  <= 1'b0;
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            mask_q  <= req_mask_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          cnt_q       <= nxt_cnt;
          total_q     <= nxt_total;
          m_q         <= nxt_m;
          b_q         <= nxt_b;
          ly_q        <= nxt_ly;
          mcast_q     <= nxt_mcast;
          base_q      <= nxt_base;
          dst_valid_q <= 1'b1;
          dst_id_q    <= nxt_id;
          dst_last_q  <= nxt_last;
          state_q     <= EXPAND;
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
          if (lk_err) begin
            dst_id_q   <= '0;
            dst_last_q <= 1'b1;
            err_q      <= 1'b1;
            state_q    <= ERR;
          end
`endif
        end
        EXPAND: begin
          if (dst_ready_i) begin
            if (dst_last_q) begin
              dst_valid_q <= 1'b0;
              dst_last_q  <= 1'b0;
              dst_id_q    <= '0;
              state_q     <= IDLE;
            end else begin
              cnt_q      <= nxt_cnt;
              dst_id_q   <= nxt_id;
              dst_last_q <= nxt_last;
            end
          end
        end
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
        ERR: begin
          if (dst_ready_i) begin
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign dst_valid_o = dst_valid_q;
  assign dst_id_o    = dst_id_q;
  assign dst_last_o  = dst_last_q;
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
  assign dst_err_o   = err_q;
`else
  assign dst_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_picobello_mcast_expander.sv
// Scoreboard bench for picobello_mcast_expander: directed requests push expected beats, a monitor pops and compares.
module tb_picobello_mcast_expander;
  import picobello_pkg::*;

  localparam int AW = 48;

  typedef struct packed {
    id_t  id;
    logic last;
    logic err;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_mask = '0;
  logic          dst_valid;
  logic          dst_ready = 1'b1;
  id_t           dst_id;
  logic          dst_last;
  logic          dst_err;

  int    checks = 0;
  int    errors = 0;
  int    ncyc = 0;
  int    beats = 0;
  int    first_cyc = 0;
  bit    first_pending = 1'b0;
  bit    stalled = 1'b0;
  bit    rand_ready = 1'b0;
  beat_t held;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  picobello_mcast_expander dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_mask_i  (req_mask),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready),
    .dst_id_o    (dst_id),
    .dst_last_o  (dst_last),
    .dst_err_o   (dst_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int p, input logic last, input logic err);
    beat_t b;
    b.id.x       = 4'(x);
    b.id.y       = 4'(y);
    b.id.port_id = 2'(p);
    b.last       = last;
    b.err        = err;
    exp_q.push_back(b);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] m);
    int n;
    @(posedge clk); #1;
    req_addr  = a;
    req_mask  = m;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!req_ready && n < 50);
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    first_cyc     = ncyc + 2;
    first_pending = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req addr=0x%0h mask=0x%0h accepted cycle %0d, %0d beats expected", a, m, first_cyc - 2, exp_q.size());
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Ready stimulus: random while rand_ready is set, otherwise always ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      dst_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge; a beat is consumed when valid and ready are both high.
  initial begin
    beat_t e;
    beat_t cur;
    forever begin
      @(negedge clk);
      ncyc++;
      cur = {dst_id, dst_last, dst_err};
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid_held", {31'd0, dst_valid}, 32'd1);
          chk("stall_payload_held", 32'(cur), 32'(held));
        end
        if (dst_valid) begin
          chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
          if (first_pending) begin
            chk("first_beat_cycle", ncyc, first_cyc);
            first_pending = 1'b0;
          end
          if (dst_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_beat: got id 0x%0h with nothing expected", 32'(cur));
            end else begin
              e = exp_q.pop_front();
              chk("beat_id", 32'(cur.id), 32'(e.id));
              chk("beat_last", {31'd0, cur.last}, {31'd0, e.last});
              chk("beat_err", {31'd0, cur.err}, {31'd0, e.err});
              $display("beat x=%0d y=%0d port=%0d last=%0b err=%0b", cur.id.x, cur.id.y, cur.id.port_id, cur.last, cur.err);
            end
            beats++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = cur;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_valid", {31'd0, dst_valid}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_id", 32'(dst_id), 32'd0);
    chk("reset_last", {31'd0, dst_last}, 32'd0);
    chk("reset_err", {31'd0, dst_err}, 32'd0);

    // Unicast through the multicast rule.
    push(1, 1, 1, 1'b1, 1'b0);
    send(48'h0000_2014_0000, 48'h0);
    wait_drain("unicast");

    // X masked: y fixed at 1, x sweeps 0..3.
    for (int x = 0; x < 4; x++) push(x, 1, 1, x == 3, 1'b0);
    send(48'h0000_2014_0000, 48'h0000_0030_0000);
    wait_drain("mc4");

    // X and Y masked: 16 beats, y fastest.
    b0 = beats;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) push(x, y, 1, (x == 3) && (y == 3), 1'b0);
    send(48'h0000_2014_0000, 48'h0000_003C_0000);
    wait_drain("mc16");
    chk("mc16_count", beats - b0, 32'd16);

    // Same 4-beat case with back-pressure.
    rand_ready = 1'b1;
    for (int x = 0; x < 4; x++) push(x, 1, 1, x == 3, 1'b0);
    send(48'h0000_2014_0000, 48'h0000_0030_0000);
    wait_drain("mc4_stall");
    rand_ready = 1'b0;

    // Unmatched address.
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
    push(0, 0, 0, 1'b1, 1'b1);
`else
    push(0, 0, 0, 1'b1, 1'b0);
`endif
    send(48'h0000_1000_0000, 48'h0);
    wait_drain("unmatched");

    // Non-multicast rule, mask zero then nonzero.
    push(5, 2, 3, 1'b1, 1'b0);
    send(48'h0000_3000_0040, 48'h0);
    wait_drain("periph");
`ifdef PICOBELLO_MCAST_EXPANDER_ERR_EN
    push(0, 0, 0, 1'b1, 1'b1);
`else
    push(5, 2, 3, 1'b1, 1'b0);
`endif
    send(48'h0000_3000_0040, 48'h0000_0030_0000);
    wait_drain("periph_masked");

    // Reset while beat 2 of 16 is presented.
    b0 = beats;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) push(x, y, 1, (x == 3) && (y == 3), 1'b0);
    send(48'h0000_2014_0000, 48'h0000_003C_0000);
    n = 0;
    while (beats < b0 + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_reach_beat2", beats - b0, 32'd2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    first_pending = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_valid", {31'd0, dst_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_id", 32'(dst_id), 32'd0);
    chk("rst_mid_last", {31'd0, dst_last}, 32'd0);
    $display("reset applied mid-expansion at beat 2");

    b0 = beats;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) push(x, y, 1, (x == 3) && (y == 3), 1'b0);
    send(48'h0000_2014_0000, 48'h0000_003C_0000);
    wait_drain("after_reset");
    chk("after_reset_count", beats - b0, 32'd16);

    repeat (5) @(negedge clk);
    #1;
    chk("end_idle_valid", {31'd0, dst_valid}, 32'd0);
    chk("end_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
